// File: rtl/writeback_arbiter_if.sv
// Writeback channel bundle: N upstream Execute X__W val/rdy channels plus the
// register-file write port and retired-op counter driven by the arbiter.
interface writeback_arbiter_if #(
  parameter int unsigned p_num_pipes = 2,
  parameter int unsigned p_data_bits = 32
);
  logic [p_num_pipes-1:0]             X_val;
  logic [p_num_pipes-1:0]             X_rdy;
  logic [5*p_num_pipes-1:0]           X_waddr;
  logic [p_data_bits*p_num_pipes-1:0] X_wdata;
  logic [p_num_pipes-1:0]             X_wen;
  logic                               rf_wen;
  logic [4:0]                         rf_waddr;
  logic [p_data_bits-1:0]             rf_wdata;
  logic [31:0]                        commit_count;

  modport master (
    output X_val, X_waddr, X_wdata, X_wen,
    input  X_rdy, rf_wen, rf_waddr, rf_wdata, commit_count
  );

  modport slave (
    input  X_val, X_waddr, X_wdata, X_wen,
    output X_rdy, rf_wen, rf_waddr, rf_wdata, commit_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: grants one X__W channel per cycle and drives
// the register-file write port from a registered copy of the winner.
module writeback_arbiter #(
  parameter int unsigned p_num_pipes = 2,
  parameter int unsigned p_data_bits = 32
) (
  input logic               clk,
  input logic               rst,
  writeback_arbiter_if.slave wb
);
  localparam int unsigned PtrW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic [PtrW-1:0]        r_ptr;
  logic                   r_rf_wen;
  logic [4:0]             r_rf_waddr;
  logic [p_data_bits-1:0] r_rf_wdata;
  logic [31:0]            r_commit_count;

  logic                   w_gnt_any;
  logic [p_num_pipes-1:0] w_gnt_oh;
  logic [PtrW-1:0]        w_ptr_nxt;
  logic [4:0]             w_sel_waddr;
  logic [p_data_bits-1:0] w_sel_wdata;
  logic                   w_sel_wen;
  logic                   w_hs;

  // Two passes give the circular order ptr..N-1 then 0..ptr-1.
  always_comb begin
    w_gnt_any   = 1'b0;
    w_gnt_oh    = '0;
    w_ptr_nxt   = r_ptr;
    w_sel_waddr = '0;
    w_sel_wdata = '0;
    w_sel_wen   = 1'b0;
    for (int i = 0; i < int'(p_num_pipes); i++) begin
      if (!w_gnt_any && wb.X_val[i] && (i >= int'(r_ptr))) begin
        w_gnt_any   = 1'b1;
        w_gnt_oh[i] = 1'b1;
        w_ptr_nxt   = (i == int'(p_num_pipes) - 1) ? '0 : PtrW'(i + 1);
        w_sel_waddr = wb.X_waddr[i*5 +: 5];
        w_sel_wdata = wb.X_wdata[i*int'(p_data_bits) +: int'(p_data_bits)];
        w_sel_wen   = wb.X_wen[i];
      end
    end
    for (int i = 0; i < int'(p_num_pipes); i++) begin
      if (!w_gnt_any && wb.X_val[i] && (i < int'(r_ptr))) begin
        w_gnt_any   = 1'b1;
        w_gnt_oh[i] = 1'b1;
        w_ptr_nxt   = (i == int'(p_num_pipes) - 1) ? '0 : PtrW'(i + 1);
        w_sel_waddr = wb.X_waddr[i*5 +: 5];
        w_sel_wdata = wb.X_wdata[i*int'(p_data_bits) +: int'(p_data_bits)];
        w_sel_wen   = wb.X_wen[i];
      end
    end
  end

  assign wb.X_rdy = rst ? '0 : w_gnt_oh;
  assign w_hs     = w_gnt_any & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr          <= '0;
      r_rf_wen       <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_commit_count <= '0;
    end else begin
      r_rf_wen <= 1'b0;
      if (w_hs) begin
        r_ptr          <= w_ptr_nxt;
        r_rf_waddr     <= w_sel_waddr;
        r_rf_wdata     <= w_sel_wdata;
        // x0 is hardwired; the op still retires and is counted.
        r_rf_wen       <= w_sel_wen & (w_sel_waddr != 5'd0);
        r_commit_count <= r_commit_count + 32'd1;
      end
    end
  end

  assign wb.rf_wen       = r_rf_wen;
  assign wb.rf_waddr     = r_rf_waddr;
  assign wb.rf_wdata     = r_rf_wdata;
  assign wb.commit_count = r_commit_count;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with three pipes and 32-bit data,
// followed by a short seeded burst checked against a small round-robin model.
module tb_writeback_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  writeback_arbiter_if #(.p_num_pipes(N), .p_data_bits(DW)) wb ();

  writeback_arbiter #(.p_num_pipes(N), .p_data_bits(DW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input int i, input logic v, input logic [4:0] a,
                          input logic [31:0] d, input logic e);
    wb.X_val[i]           = v;
    wb.X_waddr[i*5 +: 5]  = a;
    wb.X_wdata[i*32 +: 32] = d;
    wb.X_wen[i]           = e;
  endtask

  task automatic chk_rf(input string tag, input logic e, input logic [4:0] a,
                        input logic [31:0] d, input int cnt);
    chk({tag, "_wen"}, wb.rf_wen, e);
    chk({tag, "_waddr"}, wb.rf_waddr, a);
    chk({tag, "_wdata"}, wb.rf_wdata, d);
    chk({tag, "_cnt"}, wb.commit_count, cnt);
  endtask

  logic        pend [N];
  logic [4:0]  pa   [N];
  logic [31:0] pd   [N];
  logic        pe   [N];
  int          seqn [N];

  initial begin
    int mp;
    int g;
    int exp_cnt;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int p = 0; p < int'(N); p++) set_pipe(p, 1'b1, 5'd7, 32'hdead, 1'b1);
    cyc();
    cyc();
    chk_rf("reset", 1'b0, 5'd0, 32'd0, 0);
    chk("reset_rdy", wb.X_rdy, 3'b000);

    // Single write from pipe 0.
    rst = 1'b0;
    for (int p = 0; p < int'(N); p++) set_pipe(p, 1'b0, 5'd0, 32'd0, 1'b0);
    set_pipe(0, 1'b1, 5'd1, 32'd2, 1'b1);
    #1 chk("t1_rdy", wb.X_rdy, 3'b001);
    cyc();
    set_pipe(0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk_rf("t1", 1'b1, 5'd1, 32'd2, 1);

    // Both pipes valid; ptr=1 after the first grant so pipe1 wins first.
    set_pipe(0, 1'b1, 5'd1, 32'd10, 1'b1);
    set_pipe(1, 1'b1, 5'd2, 32'd20, 1'b1);
    #1 chk("t2a_rdy", wb.X_rdy, 3'b010);
    cyc();
    chk_rf("t2a", 1'b1, 5'd2, 32'd20, 2);
    set_pipe(1, 1'b1, 5'd4, 32'd40, 1'b1);
    #1 chk("t2b_rdy", wb.X_rdy, 3'b001);
    cyc();
    chk_rf("t2b", 1'b1, 5'd1, 32'd10, 3);
    set_pipe(0, 1'b1, 5'd3, 32'd30, 1'b1);
    #1 chk("t2c_rdy", wb.X_rdy, 3'b010);
    cyc();
    chk_rf("t2c", 1'b1, 5'd4, 32'd40, 4);
    set_pipe(1, 1'b0, 5'd0, 32'd0, 1'b0);
    #1 chk("t2d_rdy", wb.X_rdy, 3'b001);
    cyc();
    chk_rf("t2d", 1'b1, 5'd3, 32'd30, 5);
    set_pipe(0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1 chk("idle_rdy", wb.X_rdy, 3'b000);
    cyc();
    chk_rf("idle", 1'b0, 5'd3, 32'd30, 5);

    // x0 write suppressed and wen=0 op, both still counted.
    set_pipe(0, 1'b1, 5'd0, 32'd5, 1'b1);
    #1 chk("t3a_rdy", wb.X_rdy, 3'b001);
    cyc();
    set_pipe(0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk_rf("t3a", 1'b0, 5'd0, 32'd5, 6);
    set_pipe(1, 1'b1, 5'd3, 32'd7, 1'b0);
    #1 chk("t3b_rdy", wb.X_rdy, 3'b010);
    cyc();
    set_pipe(1, 1'b0, 5'd0, 32'd0, 1'b0);
    chk_rf("t3b", 1'b0, 5'd3, 32'd7, 7);

    // ptr=2: pipe2 alone wraps ptr to 0, twice, then pipe0 beats pipe2.
    set_pipe(2, 1'b1, 5'd9, 32'h99, 1'b1);
    #1 chk("t4a_rdy", wb.X_rdy, 3'b100);
    cyc();
    chk_rf("t4a", 1'b1, 5'd9, 32'h99, 8);
    set_pipe(2, 1'b1, 5'd10, 32'haa, 1'b1);
    #1 chk("t4b_rdy", wb.X_rdy, 3'b100);
    cyc();
    chk_rf("t4b", 1'b1, 5'd10, 32'haa, 9);
    set_pipe(0, 1'b1, 5'd11, 32'hbb, 1'b1);
    set_pipe(2, 1'b1, 5'd12, 32'hcc, 1'b1);
    #1 chk("t4c_rdy", wb.X_rdy, 3'b001);
    cyc();
    chk_rf("t4c", 1'b1, 5'd11, 32'hbb, 10);

    // Reset with ptr=1 and pipe1 valid drops the in-flight result.
    set_pipe(0, 1'b0, 5'd0, 32'd0, 1'b0);
    set_pipe(2, 1'b0, 5'd0, 32'd0, 1'b0);
    set_pipe(1, 1'b1, 5'd13, 32'hdd, 1'b1);
    rst = 1'b1;
    #1 chk("t5_rdy", wb.X_rdy, 3'b000);
    cyc();
    chk_rf("t5", 1'b0, 5'd0, 32'd0, 0);
    rst = 1'b0;
    set_pipe(0, 1'b1, 5'd14, 32'hee, 1'b1);
    #1 chk("t5b_rdy", wb.X_rdy, 3'b001);
    cyc();
    chk_rf("t5b", 1'b1, 5'd14, 32'hee, 1);

    // Seeded burst: each pipe holds its item until accepted, so order is kept.
    mp      = 1;
    exp_cnt = 1;
    for (int p = 0; p < int'(N); p++) begin
      pend[p] = 1'b0;
      seqn[p] = 0;
    end
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < int'(N); p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          pa[p]   = 5'($urandom_range(0, 31));
          pd[p]   = {8'(p), 8'(seqn[p]), 16'($urandom_range(0, 65535))};
          pe[p]   = 1'($urandom_range(0, 1));
          seqn[p]++;
        end
        set_pipe(p, pend[p], pa[p], pd[p], pe[p]);
      end
      g = -1;
      for (int k = 0; k < int'(N); k++) begin
        int idx;
        idx = (mp + k) % int'(N);
        if (g < 0 && pend[idx]) g = idx;
      end
      #1 chk("rnd_rdy", wb.X_rdy, (g < 0) ? 3'b000 : 3'(1 << g));
      cyc();
      if (g >= 0) begin
        exp_cnt++;
        chk_rf("rnd", pe[g] & (pa[g] != 5'd0), pa[g], pd[g], exp_cnt);
        pend[g] = 1'b0;
        mp      = (g == int'(N) - 1) ? 0 : g + 1;
      end else begin
        chk("rnd_idle_wen", wb.rf_wen, 1'b0);
      end
    end
    for (int p = 0; p < int'(N); p++) set_pipe(p, 1'b0, 5'd0, 32'd0, 1'b0);
    cyc();
    chk("final_cnt", wb.commit_count, exp_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
